id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: none; all widths and encodings SHALL come from lapido_defs.v (INSTRUCTION_WIDTH=32, PC_WIDTH=32, NOP_INSTRUCTION=32'h0).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 if_instruction  in  32  instruction from fetch; NOP_INSTRUCTION when fetch squashed it.
REQ-005 if_pc  in  32  PC of if_instruction (word address).
REQ-006 branch_taken  in  1  MEM-stage branch resolved taken; flush request.
REQ-007 wb_reg_write  in  1  writeback enable.
REQ-008 wb_write_addr  in  5  writeback register index.
REQ-009 wb_write_data  in  32  writeback data.
REQ-010 jump_addr  out  32  combinational jump target to fetch.
REQ-011 is_jump  out  1  combinational jump request to fetch.
REQ-012 stall_pipeline  out  1  combinational load-use stall to fetch.
REQ-013 ex_rs_data, ex_rt_data  out  32 each  registered operand values.
REQ-014 ex_imm  out  32  registered sign-extended imm16.
REQ-015 ex_pc  out  32  registered if_pc.
REQ-016 ex_rs, ex_rt, ex_rd  out  5 each  registered source indices and resolved destination.
REQ-017 ex_ctrl  out  10  registered control bundle: alu_op[3:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch_ne; field positions defined in lapido_defs.v.

Function
REQ-018 Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm16=[15:0], target=[25:0].
REQ-019 Decoded opcodes SHALL be R-type 0x00, ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02; any other opcode and NOP_INSTRUCTION SHALL decode to all-zero ex_ctrl (bubble).
REQ-020 Destination: R-type -> rd; ADDI/LW -> rt; others -> 0 with reg_write=0; reg_write SHALL be forced 0 when destination is r0.
REQ-021 BEQ/BNE SHALL set alu_op=SUB, branch_ne per opcode, and ex_imm SHALL carry the offset; MEM computes ex_pc+1+ex_imm.
REQ-022 Register file: 32x32, r0 reads 0 always, two combinational reads, one write on posedge clk when wb_reg_write=1 and wb_write_addr!=0.
REQ-023 Same-cycle write/read of same non-zero index SHALL return wb_write_data (write-through bypass).
REQ-024 Load-use: stall_pipeline=1 when registered ex_ctrl.mem_read=1, ex_rd!=0 and ex_rd equals decoded rs (if used) or rt (if used: R-type, SW, BEQ, BNE).
REQ-025 On stall the ID/EX register SHALL load a bubble (ex_ctrl=0, ex_rd=0); fetch holds PC and instruction; stall lasts exactly 1 cycle per hazard.
REQ-026 is_jump=1 when opcode=J, stall_pipeline=0 and branch_taken=0; jump_addr={if_pc[31:26], target}.
REQ-027 branch_taken=1 SHALL load a bubble into ID/EX on that edge and force is_jump=0 and stall_pipeline=0 (flush has priority over stall and jump).
REQ-028 J itself SHALL enter ID/EX as a bubble.
REQ-029 Latency: decode-to-ex_* outputs exactly one cycle; no other internal state besides register file and ID/EX register.

Reset
REQ-030 rst=0 SHALL immediately clear all ex_* outputs to 0 and all 32 registers to 0, regardless of clk.
REQ-031 Combinational outputs SHALL be 0 while rst=0; first decode occurs on the first posedge after rst rises.

Structure
REQ-032 Opcodes, ALU op codes, ex_ctrl field indices, NOP_INSTRUCTION and widths SHALL live in lapido_defs.v.
REQ-033 Register file SHALL be a sub-module named register_file; decode, hazard and ID/EX register stay in id_stage.

Verification
REQ-034 Reset: rst=0 mid-run -> all ex_* = 0 at once; after release, read r5 -> 0.
REQ-035 Writeback bypass: wb write r3=0x1234 while decoding ADD r1,r3,r3 -> next cycle ex_rs_data=ex_rt_data=0x1234.
REQ-036 Load-use: LW r2 then ADD r4,r2,r1 -> stall_pipeline=1 for one cycle, bubble in ID/EX, ADD issues next cycle with ex_rd=4.
REQ-037 Jump: J target=0x000040 at if_pc=0x10 -> is_jump=1, jump_addr=0x40 same cycle; ex_ctrl=0 next cycle.
REQ-038 Flush priority: branch_taken=1 with J and load-use hazard both present -> is_jump=0, stall_pipeline=0, ex_ctrl=0.
REQ-039 r0 protection: ADDI r0,r0,5 then wb write r0=0xFFFF -> ex_ctrl.reg_write=0, later read of r0 returns 0.

Source files
------------

// File: rtl/lapido_defs.sv
// Shared widths, opcodes, ALU codes and ex_ctrl field positions for the
// Lapido pipeline. Every stage takes its encodings from here.
package lapido_defs;

  localparam int INSTRUCTION_WIDTH = 32;
  localparam int PC_WIDTH          = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int REG_ADDR_WIDTH    = 5;
  localparam int REG_COUNT         = 32;
  localparam int CTRL_WIDTH        = 10;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0000;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_e;

  // ex_ctrl layout: {alu_op[3:0], alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch_ne}
  localparam int CTRL_ALU_OP_HI  = 9;
  localparam int CTRL_ALU_OP_LO  = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_BRANCH_NE  = 0;

  // Unknown funct codes fall back to ADD so EX always sees a defined operation.
  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      6'h20:   op = ALU_ADD;
      6'h22:   op = ALU_SUB;
      6'h24:   op = ALU_AND;
      6'h25:   op = ALU_OR;
      6'h2A:   op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file: r0 hard-wired to zero, two combinational read ports
// with write-through bypass, one synchronous write port.
module register_file
  import lapido_defs::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_a,
  input  logic [REG_ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0]     rdata_a,
  output logic [DATA_WIDTH-1:0]     rdata_b,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]     wdata
);

  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic                  wr_en_s;

  assign wr_en_s = we && (waddr != 5'd0);

  // Register array storage; r0 is never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read ports: r0 reads zero, a same-cycle write to the read index is forwarded.
  always_comb begin
    rdata_a = 32'h0000_0000;
    rdata_b = 32'h0000_0000;
    if (raddr_a == 5'd0) begin
      rdata_a = 32'h0000_0000;
    end else if (wr_en_s && (waddr == raddr_a)) begin
      rdata_a = wdata;
    end else begin
      rdata_a = regs_r[raddr_a];
    end
    if (raddr_b == 5'd0) begin
      rdata_b = 32'h0000_0000;
    end else if (wr_en_s && (waddr == raddr_b)) begin
      rdata_b = wdata;
    end else begin
      rdata_b = regs_r[raddr_b];
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: field decode, control generation, load-use
// hazard detection, jump resolution and the ID/EX pipeline register.
module id_stage
  import lapido_defs::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTRUCTION_WIDTH-1:0] if_instruction,
  input  logic [PC_WIDTH-1:0]          if_pc,
  input  logic                         branch_taken,
  input  logic                         wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_write_addr,
  input  logic [DATA_WIDTH-1:0]        wb_write_data,
  output logic [PC_WIDTH-1:0]          jump_addr,
  output logic                         is_jump,
  output logic                         stall_pipeline,
  output logic [DATA_WIDTH-1:0]        ex_rs_data,
  output logic [DATA_WIDTH-1:0]        ex_rt_data,
  output logic [DATA_WIDTH-1:0]        ex_imm,
  output logic [PC_WIDTH-1:0]          ex_pc,
  output logic [REG_ADDR_WIDTH-1:0]    ex_rs,
  output logic [REG_ADDR_WIDTH-1:0]    ex_rt,
  output logic [REG_ADDR_WIDTH-1:0]    ex_rd,
  output logic [CTRL_WIDTH-1:0]        ex_ctrl
);

  logic [5:0]                opcode_s;
  logic [REG_ADDR_WIDTH-1:0] rs_s;
  logic [REG_ADDR_WIDTH-1:0] rt_s;
  logic [REG_ADDR_WIDTH-1:0] rd_s;
  logic [5:0]                funct_s;
  logic [15:0]               imm16_s;
  logic [25:0]               target_s;
  logic [DATA_WIDTH-1:0]     rs_data_s;
  logic [DATA_WIDTH-1:0]     rt_data_s;

  logic [CTRL_WIDTH-1:0]     ctrl_s;
  logic [REG_ADDR_WIDTH-1:0] dest_s;
  logic                      use_rs_s;
  logic                      use_rt_s;
  logic                      valid_s;
  logic                      is_j_op_s;
  logic                      load_hit_s;
  logic                      bubble_s;

  assign opcode_s  = if_instruction[31:26];
  assign rs_s      = if_instruction[25:21];
  assign rt_s      = if_instruction[20:16];
  assign rd_s      = if_instruction[15:11];
  assign funct_s   = if_instruction[5:0];
  assign imm16_s   = if_instruction[15:0];
  assign target_s  = if_instruction[25:0];
  assign is_j_op_s = (opcode_s == OP_J);

  register_file u_register_file (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .rdata_a (rs_data_s),
    .rdata_b (rt_data_s),
    .we      (wb_reg_write),
    .waddr   (wb_write_addr),
    .wdata   (wb_write_data)
  );

  // Control decode; valid_s=0 marks anything that must enter ID/EX as a bubble.
  always_comb begin
    ctrl_s   = 10'd0;
    dest_s   = 5'd0;
    use_rs_s = 1'b0;
    use_rt_s = 1'b0;
    valid_s  = 1'b0;
    if (if_instruction == NOP_INSTRUCTION) begin
      valid_s = 1'b0;
    end else begin
      case (opcode_s)
        OP_RTYPE: begin
          ctrl_s[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = funct_to_alu(funct_s);
          ctrl_s[CTRL_REG_WRITE] = (rd_s != 5'd0);
          dest_s   = rd_s;
          use_rs_s = 1'b1;
          use_rt_s = 1'b1;
          valid_s  = 1'b1;
        end
        OP_ADDI: begin
          ctrl_s[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_ADD;
          ctrl_s[CTRL_ALU_SRC]   = 1'b1;
          ctrl_s[CTRL_REG_WRITE] = (rt_s != 5'd0);
          dest_s   = rt_s;
          use_rs_s = 1'b1;
          valid_s  = 1'b1;
        end
        OP_LW: begin
          ctrl_s[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_ADD;
          ctrl_s[CTRL_ALU_SRC]    = 1'b1;
          ctrl_s[CTRL_REG_WRITE]  = (rt_s != 5'd0);
          ctrl_s[CTRL_MEM_READ]   = 1'b1;
          ctrl_s[CTRL_MEM_TO_REG] = 1'b1;
          dest_s   = rt_s;
          use_rs_s = 1'b1;
          valid_s  = 1'b1;
        end
        OP_SW: begin
          ctrl_s[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_ADD;
          ctrl_s[CTRL_ALU_SRC]   = 1'b1;
          ctrl_s[CTRL_MEM_WRITE] = 1'b1;
          use_rs_s = 1'b1;
          use_rt_s = 1'b1;
          valid_s  = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          ctrl_s[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_SUB;
          ctrl_s[CTRL_BRANCH_NE] = (opcode_s == OP_BNE);
          use_rs_s = 1'b1;
          use_rt_s = 1'b1;
          valid_s  = 1'b1;
        end
        default: begin
          valid_s = 1'b0;
        end
      endcase
    end
  end

  assign load_hit_s = ex_ctrl[CTRL_MEM_READ] && (ex_rd != 5'd0) &&
                      ((use_rs_s && (ex_rd == rs_s)) || (use_rt_s && (ex_rd == rt_s)));

  // Fetch-facing controls; a flush overrides both the stall and the jump.
  always_comb begin
    stall_pipeline = 1'b0;
    is_jump        = 1'b0;
    jump_addr      = 32'h0000_0000;
    if (!rst) begin
      stall_pipeline = 1'b0;
      is_jump        = 1'b0;
      jump_addr      = 32'h0000_0000;
    end else if (branch_taken) begin
      stall_pipeline = 1'b0;
      is_jump        = 1'b0;
      jump_addr      = {if_pc[31:26], target_s};
    end else begin
      stall_pipeline = load_hit_s;
      is_jump        = is_j_op_s && !load_hit_s;
      jump_addr      = {if_pc[31:26], target_s};
    end
  end

  assign bubble_s = branch_taken || stall_pipeline || !valid_s;

  // ID/EX pipeline register; bubbles clear every field.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_ctrl    <= 10'd0;
      ex_rd      <= 5'd0;
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_rs_data <= 32'h0000_0000;
      ex_rt_data <= 32'h0000_0000;
      ex_imm     <= 32'h0000_0000;
      ex_pc      <= 32'h0000_0000;
    end else if (bubble_s) begin
      ex_ctrl    <= 10'd0;
      ex_rd      <= 5'd0;
      ex_rs      <= 5'd0;
      ex_rt      <= 5'd0;
      ex_rs_data <= 32'h0000_0000;
      ex_rt_data <= 32'h0000_0000;
      ex_imm     <= 32'h0000_0000;
      ex_pc      <= 32'h0000_0000;
    end else begin
      ex_ctrl    <= ctrl_s;
      ex_rd      <= dest_s;
      ex_rs      <= rs_s;
      ex_rt      <= rt_s;
      ex_rs_data <= rs_data_s;
      ex_rt_data <= rt_data_s;
      ex_imm     <= {{16{imm16_s[15]}}, imm16_s};
      ex_pc      <= if_pc;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed instruction stream, expected
// ID/EX contents queued at drive time and compared one cycle later.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        branch_taken;
  logic        wb_reg_write;
  logic [4:0]  wb_write_addr;
  logic [31:0] wb_write_data;
  logic [31:0] jump_addr;
  logic        is_jump;
  logic        stall_pipeline;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_ctrl;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    logic [9:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  // Expected ex_ctrl encodings: {alu_op, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch_ne}
  localparam logic [9:0] C_ADD    = 10'h090;
  localparam logic [9:0] C_ADDI   = 10'h0B0;
  localparam logic [9:0] C_ADDI0  = 10'h0A0;
  localparam logic [9:0] C_LW     = 10'h0BA;
  localparam logic [9:0] C_SW     = 10'h0A4;
  localparam logic [9:0] C_BEQ    = 10'h180;
  localparam logic [9:0] C_BNE    = 10'h181;

  id_stage dut (
    .clk            (clk),
    .rst            (rst),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .branch_taken   (branch_taken),
    .wb_reg_write   (wb_reg_write),
    .wb_write_addr  (wb_write_addr),
    .wb_write_data  (wb_write_data),
    .jump_addr      (jump_addr),
    .is_jump        (is_jump),
    .stall_pipeline (stall_pipeline),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_pc          (ex_pc),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_ctrl        (ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_type(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  function automatic exp_t mk(input logic [9:0] ctrl, input logic [4:0] rd, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    e.ctrl = ctrl; e.rd = rd; e.rs = rs; e.rt = rt;
    e.rs_data = rsd; e.rt_data = rtd; e.imm = imm; e.pc = pc;
    return e;
  endfunction

  function automatic exp_t bub();
    return mk(10'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endfunction

  // One decode cycle: drive, check fetch-facing outputs mid-cycle, compare ID/EX after the edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic bt, input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                      input logic exp_stall, input logic exp_jump, input logic [31:0] exp_ja,
                      input exp_t e);
    exp_t got;
    if_instruction = instr;
    if_pc          = pc;
    branch_taken   = bt;
    wb_reg_write   = wbw;
    wb_write_addr  = wba;
    wb_write_data  = wbd;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall_pipeline), 32'(exp_stall));
    chk({tag, ".is_jump"}, 32'(is_jump), 32'(exp_jump));
    if (exp_jump) chk({tag, ".jump_addr"}, jump_addr, exp_ja);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    wb_reg_write = 1'b0;
    branch_taken = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk({tag, ".ctrl"},    32'(ex_ctrl), 32'(got.ctrl));
      chk({tag, ".rd"},      32'(ex_rd),   32'(got.rd));
      chk({tag, ".rs"},      32'(ex_rs),   32'(got.rs));
      chk({tag, ".rt"},      32'(ex_rt),   32'(got.rt));
      chk({tag, ".rs_data"}, ex_rs_data,   got.rs_data);
      chk({tag, ".rt_data"}, ex_rt_data,   got.rt_data);
      chk({tag, ".imm"},     ex_imm,       got.imm);
      chk({tag, ".pc"},      ex_pc,        got.pc);
    end
  endtask

  task automatic chk_ex_zero(input string tag);
    chk({tag, ".ctrl0"},    32'(ex_ctrl), 32'd0);
    chk({tag, ".rd0"},      32'(ex_rd),   32'd0);
    chk({tag, ".rs0"},      32'(ex_rs),   32'd0);
    chk({tag, ".rt0"},      32'(ex_rt),   32'd0);
    chk({tag, ".rs_data0"}, ex_rs_data,   32'd0);
    chk({tag, ".rt_data0"}, ex_rt_data,   32'd0);
    chk({tag, ".imm0"},     ex_imm,       32'd0);
    chk({tag, ".pc0"},      ex_pc,        32'd0);
    chk({tag, ".stall0"},   32'(stall_pipeline), 32'd0);
    chk({tag, ".jump0"},    32'(is_jump),   32'd0);
    chk({tag, ".jaddr0"},   jump_addr,      32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    if_instruction = j_type(26'h000040);
    if_pc          = 32'h0000_0010;
    branch_taken   = 1'b0;
    wb_reg_write   = 1'b0;
    wb_write_addr  = 5'd0;
    wb_write_data  = 32'h0;
    #3;
    chk_ex_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    step("bypass_add", r_type(5'd3, 5'd3, 5'd1, 6'h20), 32'h04, 1'b0, 1'b1, 5'd3, 32'h1234,
         1'b0, 1'b0, 32'h0, mk(C_ADD, 5'd1, 5'd3, 5'd3, 32'h1234, 32'h1234, 32'h0820, 32'h04));
    step("lw_r2", i_type(6'h23, 5'd3, 5'd2, 16'h0010), 32'h08, 1'b0, 1'b1, 5'd1, 32'h55,
         1'b0, 1'b0, 32'h0, mk(C_LW, 5'd2, 5'd3, 5'd2, 32'h1234, 32'h0, 32'h10, 32'h08));
    step("load_use", r_type(5'd2, 5'd1, 5'd4, 6'h20), 32'h0C, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b1, 1'b0, 32'h0, bub());
    step("after_stall", r_type(5'd2, 5'd1, 5'd4, 6'h20), 32'h0C, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_ADD, 5'd4, 5'd2, 5'd1, 32'h0, 32'h55, 32'h2020, 32'h0C));
    step("jump", j_type(26'h000040), 32'h10, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b1, 32'h40, bub());
    step("sw", i_type(6'h2B, 5'd1, 5'd2, 16'hFFFC), 32'h14, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_SW, 5'd0, 5'd1, 5'd2, 32'h55, 32'h0, 32'hFFFF_FFFC, 32'h14));
    step("bne", i_type(6'h05, 5'd1, 5'd4, 16'hFFF8), 32'h18, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_BNE, 5'd0, 5'd1, 5'd4, 32'h55, 32'h0, 32'hFFFF_FFF8, 32'h18));
    step("beq", i_type(6'h04, 5'd1, 5'd1, 16'h0003), 32'h1C, 1'b0, 1'b1, 5'd4, 32'hABCD,
         1'b0, 1'b0, 32'h0, mk(C_BEQ, 5'd0, 5'd1, 5'd1, 32'h55, 32'h55, 32'h3, 32'h1C));
    step("lw_r5", i_type(6'h23, 5'd1, 5'd5, 16'h0000), 32'h20, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_LW, 5'd5, 5'd1, 5'd5, 32'h55, 32'h0, 32'h0, 32'h20));
    step("flush_hazard", r_type(5'd5, 5'd5, 5'd6, 6'h20), 32'h24, 1'b1, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, bub());
    step("flush_jump", j_type(26'h000123), 32'h28, 1'b1, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, bub());
    step("addi_r0", i_type(6'h08, 5'd0, 5'd0, 16'h0005), 32'h30, 1'b0, 1'b1, 5'd0, 32'hFFFF,
         1'b0, 1'b0, 32'h0, mk(C_ADDI0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h5, 32'h30));
    step("read_r0", r_type(5'd0, 5'd3, 5'd7, 6'h20), 32'h34, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_ADD, 5'd7, 5'd0, 5'd3, 32'h0, 32'h1234, 32'h3820, 32'h34));
    step("addi_r9", i_type(6'h08, 5'd4, 5'd9, 16'h8001), 32'h36, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_ADDI, 5'd9, 5'd4, 5'd9, 32'hABCD, 32'h0, 32'hFFFF_8001, 32'h36));
    step("bad_opcode", i_type(6'h3F, 5'd3, 5'd3, 16'h1111), 32'h38, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, bub());
    step("nop", 32'h0000_0000, 32'h3C, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, bub());
    step("no_we", r_type(5'd9, 5'd9, 5'd8, 6'h20), 32'h40, 1'b0, 1'b0, 5'd9, 32'hDEAD,
         1'b0, 1'b0, 32'h0, mk(C_ADD, 5'd8, 5'd9, 5'd9, 32'h0, 32'h0, 32'h4020, 32'h40));

    // Mid-run reset while ID/EX holds a live instruction.
    if_instruction = j_type(26'h000040);
    #1;
    rst = 1'b0;
    #1;
    chk_ex_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("post_reset", r_type(5'd5, 5'd3, 5'd10, 6'h20), 32'h44, 1'b0, 1'b0, 5'd0, 32'h0,
         1'b0, 1'b0, 32'h0, mk(C_ADD, 5'd10, 5'd5, 5'd3, 32'h0, 32'h0, 32'h5020, 32'h44));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
